// File: rtl/pwm_sched_pkg.sv
// Shared types and helpers for the PWM channel scheduler.
// The ramp feature is selected by the PWM_SCHED_RAMP_EN macro in the top.
package pwm_sched_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      UPDATE = 1'b1
   } state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Difference is taken wide and signed, so neither end of the duty range can wrap.
   function automatic int ramp_step(input int cur, input int tgt, input int step);
      int diff;
      diff = tgt - cur;
      if ((diff <= step) && (diff >= -step))
         return tgt;
      else if (diff > 0)
         return cur + step;
      else
         return cur - step;
   endfunction

endpackage

// File: rtl/pwm_channel_scheduler_timebase.sv
// Shared PWM timebase: prescaler feeding a free-running period counter.
// Both counters hold their value while enable_i is low.
module pwm_timebase #(
   parameter int CNT_W    = 8,
   parameter int PRESCALE = 16384
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable_i,
   output logic             tick_o,
   output logic [CNT_W-1:0] pcnt_o,
   output logic             frame_end_o
);
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]  presc_q, presc_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;

   assign tick_o      = enable_i && (presc_q == PS_W'(PRESCALE - 1));
   assign frame_end_o = tick_o && (pcnt_q == {CNT_W{1'b1}});
   assign pcnt_o      = pcnt_q;

   always_comb begin
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      if (tick_o) begin
         presc_d = '0;
         pcnt_d  = pcnt_q + CNT_W'(1);
      end else if (enable_i) begin
         presc_d = presc_q + PS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Multi-channel PWM scheduler: host targets are walked into applied duties at frame ends.
// Define PWM_SCHED_RAMP_EN for STEP-limited ramping; otherwise targets load directly.
module pwm_channel_scheduler
   import pwm_sched_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int PRESCALE = 16384,
   parameter int STEP     = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ch_w(NUM_CH)-1:0]   cmd_ch,
   input  logic [CNT_W-1:0]          cmd_duty,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic                      frame_start,
   output logic                      busy,
   output logic                      cmd_err
);
   localparam int CH_W = ch_w(NUM_CH);
   localparam int K_W  = $clog2(NUM_CH + 1);
`ifdef PWM_SCHED_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif
   // Without ramping, a step wider than the duty range makes every walk land on target.
   localparam int EFF_STEP = RAMP_EN ? STEP : (1 << CNT_W);

   state_e             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [CH_W-1:0]    kidx;
   logic [CNT_W-1:0]   tgt_q [NUM_CH];
   logic [CNT_W-1:0]   tgt_d [NUM_CH];
   logic [CNT_W-1:0]   cur_q [NUM_CH];
   logic [CNT_W-1:0]   cur_d [NUM_CH];
   logic [CNT_W-1:0]   act_q [NUM_CH];
   logic [CNT_W-1:0]   act_d [NUM_CH];
   logic [CNT_W-1:0]   walk_duty;
   logic [NUM_CH-1:0]  pwm_q, pwm_d;
   logic               ready_q, ready_d;
   logic               fs_q, fs_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   pcnt;
   logic               frame_end;
   logic               tick_unused;

   pwm_timebase #(
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk         (clk),
      .resetn      (resetn),
      .enable_i    (enable),
      .tick_o      (tick_unused),
      .pcnt_o      (pcnt),
      .frame_end_o (frame_end)
   );

   assign kidx      = k_q[CH_W-1:0];
   assign walk_duty = CNT_W'(ramp_step(int'(cur_q[kidx]), int'(tgt_q[kidx]), EFF_STEP));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      tgt_d   = tgt_q;
      cur_d   = cur_q;
      act_d   = act_q;
      fs_d    = 1'b0;
      err_d   = err_q;
      if (cmd_valid && ready_q) begin
         if (int'(cmd_ch) < NUM_CH) tgt_d[cmd_ch] = cmd_duty;
         else err_d = 1'b1;
      end
      case (state_q)
         RUN: begin
            if (frame_end) begin
               state_d = UPDATE;
               k_d     = '0;
            end
         end
         default: begin
            // One channel per cycle, then a final cycle that publishes all channels together.
            if (k_q == K_W'(NUM_CH)) begin
               act_d   = cur_q;
               fs_d    = 1'b1;
               state_d = RUN;
            end else begin
               cur_d[kidx] = walk_duty;
               k_d         = k_q + K_W'(1);
            end
         end
      endcase
      ready_d = (state_d == RUN);
   end

   always_comb begin
      busy_d = 1'b0;
      pwm_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy_d   = busy_d | (cur_q[i] != tgt_q[i]);
         pwm_d[i] = enable && (pcnt < act_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= RUN;
         k_q     <= '0;
         ready_q <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         pwm_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            tgt_q[i] <= '0;
            cur_q[i] <= '0;
            act_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ready_q <= ready_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         pwm_q   <= pwm_d;
         tgt_q   <= tgt_d;
         cur_q   <= cur_d;
         act_q   <= act_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign pwm_out     = pwm_q;
   assign frame_start = fs_q;
   assign busy        = busy_q;
   assign cmd_err     = err_q;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Directed bench for pwm_channel_scheduler (NUM_CH=4, CNT_W=4, PRESCALE=8, STEP=2),
// plus a 3-channel instance for out-of-range commands; follows PWM_SCHED_RAMP_EN.
module tb_pwm_channel_scheduler;
`ifdef PWM_SCHED_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif
   localparam int PERIOD = 128;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_ch;
   logic [3:0] cmd_duty;
   logic [3:0] pwm_out;
   logic       frame_start;
   logic       busy;
   logic       cmd_err;

   logic       cmd_valid3;
   logic       cmd_ready3;
   logic [1:0] cmd_ch3;
   logic [3:0] cmd_duty3;
   logic [2:0] pwm_out3;
   logic       frame_start3;
   logic       busy3;
   logic       cmd_err3;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pwm_channel_scheduler #(.NUM_CH(4), .CNT_W(4), .PRESCALE(8), .STEP(2)) u_dut (
      .clk(clk), .resetn(resetn), .enable(enable), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .pwm_out(pwm_out),
      .frame_start(frame_start), .busy(busy), .cmd_err(cmd_err)
   );

   pwm_channel_scheduler #(.NUM_CH(3), .CNT_W(4), .PRESCALE(8), .STEP(2)) u_dut3 (
      .clk(clk), .resetn(resetn), .enable(enable), .cmd_valid(cmd_valid3),
      .cmd_ready(cmd_ready3), .cmd_ch(cmd_ch3), .cmd_duty(cmd_duty3), .pwm_out(pwm_out3),
      .frame_start(frame_start3), .busy(busy3), .cmd_err(cmd_err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] ch, input logic [3:0] d);
      int n;
      n = 0;
      cmd_ch    = ch;
      cmd_duty  = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_wait", n < 50, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send3(input logic [1:0] ch, input logic [3:0] d);
      int n;
      n = 0;
      cmd_ch3    = ch;
      cmd_duty3  = d;
      cmd_valid3 = 1'b1;
      while (!cmd_ready3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send3_ready_wait", n < 50, 1);
      @(negedge clk);
      cmd_valid3 = 1'b0;
   endtask

   task automatic wait_fs(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 400);
      chk(tag, frame_start, 1);
   endtask

   // Called on a frame_start cycle; samples one full period of applied duties.
   task automatic measure(input string tag, input int dis_at, input int dis_len,
                          input int e0, input int e1, input int e2, input int e3);
      int cnt [4];
      int fs_seen;
      int n;
      n       = PERIOD + dis_len;
      fs_seen = 0;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) cnt[c] += int'(pwm_out[c]);
         fs_seen += int'(frame_start);
         if (dis_len > 0) begin
            if (i == dis_at) begin
               chk({tag, "_hi_before_disable"}, pwm_out[1], 1);
               enable = 1'b0;
            end
            if (i == dis_at + 1) chk({tag, "_zero_after_disable"}, pwm_out, 0);
            if (i == dis_at + dis_len) begin
               chk({tag, "_zero_while_disabled"}, pwm_out, 0);
               enable = 1'b1;
            end
            if (i == dis_at + dis_len + 1) chk({tag, "_resume_same_pcnt"}, pwm_out[1], 1);
         end
      end
      chk({tag, "_fs_at_end"}, frame_start, 1);
      chk({tag, "_fs_count"}, fs_seen, 1);
      chk({tag, "_ch0"}, cnt[0], 8 * e0);
      chk({tag, "_ch1"}, cnt[1], 8 * e1);
      chk({tag, "_ch2"}, cnt[2], 8 * e2);
      chk({tag, "_ch3"}, cnt[3], 8 * e3);
   endtask

   initial begin
      int n;
      int lows;
      resetn     = 1'b0;
      enable     = 1'b1;
      cmd_valid  = 1'b0;
      cmd_ch     = '0;
      cmd_duty   = '0;
      cmd_valid3 = 1'b0;
      cmd_ch3    = '0;
      cmd_duty3  = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_pwm_out", pwm_out, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_err", cmd_err, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("ready_after_release", cmd_ready, 1);

      wait_fs("fs_first", n);
      chk("first_frame_timing", n, PERIOD + 4);
      chk("busy_idle", busy, 0);
      measure("idle_frame", 0, 0, 0, 0, 0, 0);

      // Channel 1 ramps towards 6.
      send(2'd1, 4'd6);
      @(negedge clk);
      chk("busy_after_cmd", busy, 1);
      wait_fs("fs_ch1_a", n);
      chk("busy_ch1_a", busy, RAMP ? 1 : 0);
      measure("ch1_a", 0, 0, 0, RAMP ? 2 : 6, 0, 0);
      chk("busy_ch1_b", busy, RAMP ? 1 : 0);
      measure("ch1_b", 0, 0, 0, RAMP ? 4 : 6, 0, 0);
      chk("busy_ch1_c", busy, 0);
      measure("ch1_c", 0, 0, 0, 6, 0, 0);

      // Last write to a channel within a frame wins.
      send(2'd0, 4'd15);
      send(2'd0, 4'd3);
      wait_fs("fs_ch0_a", n);
      measure("ch0_a", 0, 0, RAMP ? 2 : 3, 6, 0, 0);
      measure("ch0_b", 0, 0, 3, 6, 0, 0);

      // Command pending while the walk holds cmd_ready low.
      n = 0;
      while (cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_drop_seen", cmd_ready, 0);
      cmd_ch    = 2'd2;
      cmd_duty  = 4'd9;
      cmd_valid = 1'b1;
      lows = 1;
      n    = 0;
      do begin
         @(negedge clk);
         n++;
         if (!cmd_ready) lows++;
      end while (!cmd_ready && n < 20);
      chk("ready_low_cycles", lows, 5);
      chk("ready_back_with_fs", frame_start, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_fs("fs_ch2_a", n);
      measure("ch2_a", 0, 0, 3, 6, RAMP ? 2 : 9, 0);

      // Freeze the timebase for 10 cycles in the middle of a frame.
      measure("disable", 20, 10, 3, 6, RAMP ? 4 : 9, 0);

      // Out-of-range channel on the 3-channel instance.
      chk("err3_clear", cmd_err3, 0);
      send3(2'd3, 4'd7);
      chk("err3_set", cmd_err3, 1);
      repeat (3) @(negedge clk);
      chk("err3_sticky", cmd_err3, 1);
      chk("err3_no_target_change", busy3, 0);
      send3(2'd2, 4'd7);
      @(negedge clk);
      chk("busy3_in_range", busy3, 1);
      chk("err3_still_set", cmd_err3, 1);
      chk("main_err_clear", cmd_err, 0);

      // Reset in the middle of a walk.
      n = 0;
      while (cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("walk_entered", cmd_ready, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst2_err3", cmd_err3, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_pwm", pwm_out, 0);
      chk("rst2_fs", frame_start, 0);
      chk("rst2_ready", cmd_ready, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst2_ready_rise", cmd_ready, 1);
      wait_fs("fs_after_rst2", n);
      chk("rst2_no_early_fs", n, PERIOD + 4);
      chk("rst2_busy_idle", busy, 0);
      measure("after_rst2", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
